// File: rtl/sol_claim_responder.sv
// Claim/response responder: captures a solver claim, checks hash <= target chunk by chunk (MSB first)
// and answers on sol_response. Optional macro SOL_REJECT_CNT_EN adds a saturating reject_count output.
module sol_claim_responder #(
  parameter int HASH_W  = 256,
  parameter int NONCE_W = 32,
  parameter int CHUNK_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sol_claim,
  input  logic [NONCE_W-1:0] claim_nonce,
  input  logic [HASH_W-1:0]  claim_hash,
  input  logic [HASH_W-1:0]  target,
  output logic [1:0]         sol_response,
  output logic               result_valid,
  output logic [NONCE_W-1:0] result_nonce,
  input  logic               result_ready,
  output logic               busy
`ifdef SOL_REJECT_CNT_EN
  ,
  output logic [15:0]        reject_count
`endif
);

  localparam int NCHUNK = HASH_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    REJECT,
    REPORT,
    ACCEPT
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [NONCE_W-1:0] nonce_q;
  logic [HASH_W-1:0]  hash_q;
  logic [HASH_W-1:0]  target_q;
  logic [CHUNK_W-1:0] hash_chunk;
  logic [CHUNK_W-1:0] target_chunk;

  // Captured words shift left after each equal chunk, so the chunk under
  // test is always the top slice; idx only tracks when the last one is reached.
  assign hash_chunk   = hash_q[HASH_W-1 -: CHUNK_W];
  assign target_chunk = target_q[HASH_W-1 -: CHUNK_W];
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      nonce_q      <= '0;
      hash_q       <= '0;
      target_q     <= '0;
      sol_response <= 2'b00;
      result_valid <= 1'b0;
      result_nonce <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sol_claim) begin
            nonce_q  <= claim_nonce;
            hash_q   <= claim_hash;
            target_q <= target;
            idx      <= '0;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          if (hash_chunk < target_chunk || (hash_chunk == target_chunk && idx == LAST_IDX)) begin
            result_valid <= 1'b1;
            result_nonce <= nonce_q;
            state        <= REPORT;
          end else if (hash_chunk > target_chunk) begin
            sol_response <= 2'b01;
            state        <= REJECT;
          end else begin
            idx      <= idx + IDX_W'(1);
            hash_q   <= hash_q << CHUNK_W;
            target_q <= target_q << CHUNK_W;
          end
        end
        REJECT: begin
          sol_response <= 2'b00;
          state        <= IDLE;
        end
        REPORT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            sol_response <= 2'b10;
            state        <= ACCEPT;
          end
        end
        ACCEPT: begin
          sol_response <= 2'b00;
          state        <= IDLE;
        end
        default: begin
          sol_response <= 2'b00;
          result_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

`ifdef SOL_REJECT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject_count <= '0;
    end else if (state == REJECT && reject_count != '1) begin
      reject_count <= reject_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sol_claim_responder.sv
// Directed self-checking bench for sol_claim_responder: accept/reject paths, early exit,
// back-pressure, reset mid-compare and claims ignored while busy.
module tb_sol_claim_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         sol_claim;
  logic [31:0]  claim_nonce;
  logic [255:0] claim_hash;
  logic [255:0] target;
  logic [1:0]   sol_response;
  logic         result_valid;
  logic [31:0]  result_nonce;
  logic         result_ready;
  logic         busy;
`ifdef SOL_REJECT_CNT_EN
  logic [15:0]  reject_count;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_rej  = 0;

  always #5 clk = ~clk;

  sol_claim_responder #(.HASH_W(256), .NONCE_W(32), .CHUNK_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .sol_claim    (sol_claim),
    .claim_nonce  (claim_nonce),
    .claim_hash   (claim_hash),
    .target       (target),
    .sol_response (sol_response),
    .result_valid (result_valid),
    .result_nonce (result_nonce),
    .result_ready (result_ready),
    .busy         (busy)
`ifdef SOL_REJECT_CNT_EN
    ,
    .reject_count (reject_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Claim, count compare cycles until a decision, then walk the accept or reject path.
  task automatic run_claim(input string tag, input logic [31:0] n, input logic [255:0] h,
                           input logic [255:0] t, input bit acc, input int cyc, input int hold);
    int steps;
    result_ready = (hold == 0);
    sol_claim    = 1'b1;
    claim_nonce  = n;
    claim_hash   = h;
    target       = t;
    step();
    sol_claim    = 1'b0;
    claim_nonce  = ~n;
    claim_hash   = ~h;
    target       = ~t;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    check({tag, ".resp_cmp"}, 64'(sol_response), 64'd0);
    steps = 0;
    while (!result_valid && sol_response == 2'b00 && steps < 40) begin
      step();
      steps++;
    end
    check({tag, ".cycles"}, 64'(steps), 64'(cyc));
    if (acc) begin
      check({tag, ".valid"}, 64'(result_valid), 64'd1);
      check({tag, ".nonce"}, 64'(result_nonce), 64'(n));
      check({tag, ".resp_rep"}, 64'(sol_response), 64'd0);
      for (int i = 0; i < hold; i++) begin
        step();
        check({tag, ".hold_valid"}, 64'(result_valid), 64'd1);
        check({tag, ".hold_nonce"}, 64'(result_nonce), 64'(n));
        check({tag, ".hold_resp"}, 64'(sol_response), 64'd0);
      end
      result_ready = 1'b1;
      step();
      check({tag, ".resp_acc"}, 64'(sol_response), 64'd2);
      check({tag, ".valid_drop"}, 64'(result_valid), 64'd0);
    end else begin
      exp_rej++;
      check({tag, ".resp_rej"}, 64'(sol_response), 64'd1);
      check({tag, ".valid_rej"}, 64'(result_valid), 64'd0);
    end
    step();
    check({tag, ".resp_end"}, 64'(sol_response), 64'd0);
    check({tag, ".idle"}, 64'(busy), 64'd0);
    result_ready = 1'b0;
  endtask

  logic [255:0] eq_pat;
  int           steps6;

  initial begin
    eq_pat       = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    rst          = 1'b1;
    sol_claim    = 1'b0;
    claim_nonce  = '0;
    claim_hash   = '0;
    target       = '0;
    result_ready = 1'b0;
    @(negedge clk);
    check("rst.resp", 64'(sol_response), 64'd0);
    check("rst.valid", 64'(result_valid), 64'd0);
    check("rst.nonce", 64'(result_nonce), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();

    run_claim("t1", 32'hDEAD_0001, {32'h0, 32'h0000_1234, 192'h0}, {32'h0, 32'hFFFF_FFFF, 192'h0}, 1'b1, 2, 0);
    run_claim("t2", 32'hDEAD_0002, {32'h1, 224'h0}, {32'h0, {224{1'b1}}}, 1'b0, 1, 0);
    run_claim("t3", 32'hDEAD_0003, eq_pat, eq_pat, 1'b1, 8, 0);
    run_claim("t4", 32'hDEAD_0004, {32'h0F, 224'h0}, {32'h10, 224'h0}, 1'b1, 1, 5);
    run_claim("rej_c2", 32'h0000_0005, {64'h0, 32'h6, 160'h0}, {64'h0, 32'h5, 160'h0}, 1'b0, 3, 0);
    run_claim("acc_c7", 32'h0000_0006, {224'h0, 32'h1}, {224'h0, 32'h2}, 1'b1, 8, 0);
    run_claim("rej_c7", 32'h0000_0007, {224'h0, 32'h1}, 256'h0, 1'b0, 8, 0);

    // Reset asserted asynchronously once the compare has reached chunk 3.
    sol_claim   = 1'b1;
    claim_nonce = 32'h5555_0005;
    claim_hash  = eq_pat;
    target      = eq_pat;
    step();
    sol_claim = 1'b0;
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    check("t5.busy", 64'(busy), 64'd0);
    check("t5.resp", 64'(sol_response), 64'd0);
    check("t5.valid", 64'(result_valid), 64'd0);
    check("t5.nonce", 64'(result_nonce), 64'd0);
    exp_rej = 0;
`ifdef SOL_REJECT_CNT_EN
    check("t5.rej_cnt", 64'(reject_count), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step();
    run_claim("t5.after", 32'h5555_0006, eq_pat, eq_pat, 1'b1, 8, 0);

    // A second claim pulsed mid-compare must not disturb the one in flight.
    result_ready = 1'b1;
    sol_claim    = 1'b1;
    claim_nonce  = 32'h6666_0001;
    claim_hash   = eq_pat;
    target       = eq_pat;
    step();
    claim_nonce  = 32'h7777_0002;
    claim_hash   = '1;
    target       = '0;
    step();
    sol_claim = 1'b0;
    steps6 = 1;
    while (!result_valid && sol_response == 2'b00 && steps6 < 40) begin
      step();
      steps6++;
    end
    check("t6.cycles", 64'(steps6), 64'd8);
    check("t6.valid", 64'(result_valid), 64'd1);
    check("t6.nonce", 64'(result_nonce), 64'h6666_0001);
    step();
    check("t6.resp_acc", 64'(sol_response), 64'd2);
    step();
    check("t6.idle", 64'(busy), 64'd0);
    result_ready = 1'b0;

    run_claim("rej_a", 32'h1, {32'h2, 224'h0}, {32'h1, 224'h0}, 1'b0, 1, 0);
    run_claim("rej_b", 32'h2, {32'h2, 224'h0}, {32'h1, 224'h0}, 1'b0, 1, 0);
    run_claim("rej_c", 32'h3, {32'h2, 224'h0}, {32'h1, 224'h0}, 1'b0, 1, 0);
`ifdef SOL_REJECT_CNT_EN
    check("cnt.three", 64'(reject_count), 64'(exp_rej));
    force dut.reject_count = 16'hFFFF;
    @(negedge clk);
    release dut.reject_count;
    run_claim("cnt.sat_rej", 32'h4, {32'h2, 224'h0}, {32'h1, 224'h0}, 1'b0, 1, 0);
    check("cnt.sat", 64'(reject_count), 64'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
